// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit
// Description : Radix-2 restoring 32-bit divider, signed/unsigned, with a
//               sign fix-up cycle. Result {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   div_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dmag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_accept;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_shift;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_a_neg     = is_signed & dividend[WIDTH-1];
    assign w_b_neg     = is_signed & divisor[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag     = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_div_zero  = (divisor == '0);
    assign w_ovf       = is_signed && (dividend == c_int_min) && (divisor == '1);
    assign w_accept    = (r_state == S_IDLE) && start && !flush;

    // The bit shifted out of the remainder is kept as the trial's MSB so a
    // remainder near 2^WIDTH-1 cannot overflow the subtract.
    assign w_rem_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_trial     = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dmag};
    assign w_quo_fix   = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix   = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (w_div_zero || w_ovf) ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == c_last)
                    w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
        w_done_nxt = (r_state == S_FIX) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_dmag     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            div_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt  <= '0;
                        r_dmag <= w_b_mag;
                        if (w_div_zero) begin
                            r_quo   <= '1;
                            r_rem   <= dividend;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_ovf) begin
                            r_quo   <= c_int_min;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_shift;
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!flush)
                        div_result <= {w_rem_fix, w_quo_fix};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_unit
// Description : Directed self-checking bench for div_iter_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [63:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .flush      (flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    // Issues one operation in cycle 0 and observes cycles 1..window.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int window, output int first_done, output int n_done,
                          output logic [63:0] res, output int b_first, output int b_last,
                          output int b_cnt);
        @(posedge clk); #1;
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        first_done = -1; n_done = 0; res = '0; b_first = -1; b_last = -1; b_cnt = 0;
        for (int k = 1; k <= window; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    res = div_result;
                end
            end
            if (busy) begin
                if (b_first < 0) b_first = k;
                b_last = k;
                b_cnt++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (div_result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", div_result); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_unsigned;
        int fd, nd, bf, bl, bc;
        logic [63:0] r;
        run_op(32'd100, 32'd7, 1'b0, 40, fd, nd, r, bf, bl, bc);
        n_checks += 7;
        if (fd !== 34) begin n_fail++; $display("FAIL u100_7_done_cycle: got %0d expected 34", fd); end
        if (nd !== 1) begin n_fail++; $display("FAIL u100_7_done_count: got %0d expected 1", nd); end
        if (r !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL u100_7_result: got %h expected 000000020000000e", r); end
        if (bf !== 1) begin n_fail++; $display("FAIL u100_7_busy_first: got %0d expected 1", bf); end
        if (bl !== 33) begin n_fail++; $display("FAIL u100_7_busy_last: got %0d expected 33", bl); end
        if (bc !== 33) begin n_fail++; $display("FAIL u100_7_busy_count: got %0d expected 33", bc); end
        if (div_result !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL u100_7_hold: got %h expected 000000020000000e", div_result); end
    endtask

    task automatic test_signed;
        int fd, nd, bf, bl, bc;
        logic [63:0] r;
        run_op(32'hFFFFFFF9, 32'h2, 1'b1, 40, fd, nd, r, bf, bl, bc);
        n_checks += 2;
        if (fd !== 34) begin n_fail++; $display("FAIL sneg7_2_done_cycle: got %0d expected 34", fd); end
        if (r !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL sneg7_2_result: got %h expected fffffffffffffffd", r); end
        run_op(32'h7, 32'hFFFFFFFE, 1'b1, 40, fd, nd, r, bf, bl, bc);
        n_checks += 2;
        if (nd !== 1) begin n_fail++; $display("FAIL s7_neg2_done_count: got %0d expected 1", nd); end
        if (r !== 64'h00000001_FFFFFFFD) begin n_fail++; $display("FAIL s7_neg2_result: got %h expected 00000001fffffffd", r); end
    endtask

    task automatic test_special;
        int fd, nd, bf, bl, bc;
        logic [63:0] r;
        for (int m = 0; m < 2; m++) begin
            run_op(32'd5, 32'd0, m[0], 40, fd, nd, r, bf, bl, bc);
            n_checks += 3;
            if (fd !== 2) begin n_fail++; $display("FAIL div0_mode%0d_done_cycle: got %0d expected 2", m, fd); end
            if (r !== 64'h00000005_FFFFFFFF) begin n_fail++; $display("FAIL div0_mode%0d_result: got %h expected 00000005ffffffff", m, r); end
            if (bc !== 1) begin n_fail++; $display("FAIL div0_mode%0d_busy_count: got %0d expected 1", m, bc); end
        end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 40, fd, nd, r, bf, bl, bc);
        n_checks += 3;
        if (fd !== 2) begin n_fail++; $display("FAIL sovf_done_cycle: got %0d expected 2", fd); end
        if (nd !== 1) begin n_fail++; $display("FAIL sovf_done_count: got %0d expected 1", nd); end
        if (r !== 64'h00000000_80000000) begin n_fail++; $display("FAIL sovf_result: got %h expected 0000000080000000", r); end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 40, fd, nd, r, bf, bl, bc);
        n_checks += 2;
        if (fd !== 34) begin n_fail++; $display("FAIL uovf_done_cycle: got %0d expected 34", fd); end
        if (r !== 64'h80000000_00000000) begin n_fail++; $display("FAIL uovf_result: got %h expected 8000000000000000", r); end
    endtask

    task automatic test_boundary;
        int fd, nd, bf, bl, bc;
        logic [63:0] r;
        run_op(32'hFFFFFFFF, 32'h1, 1'b0, 40, fd, nd, r, bf, bl, bc);
        n_checks++;
        if (r !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL umax_1_result: got %h expected 00000000ffffffff", r); end
        run_op(32'h0, 32'h12345678, 1'b0, 40, fd, nd, r, bf, bl, bc);
        n_checks += 2;
        if (fd !== 34) begin n_fail++; $display("FAIL zero_div_done_cycle: got %0d expected 34", fd); end
        if (r !== 64'h0) begin n_fail++; $display("FAIL zero_div_result: got %h expected 0", r); end
    endtask

    task automatic test_flush;
        logic [63:0] prev;
        logic [63:0] r;
        int fd, nd, bad_hold;
        prev = div_result;
        fd = -1; nd = 0; bad_hold = 0; r = '0;
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
            end
            if (k == 12) begin dividend = 32'd9; divisor = 32'd4; start = 1'b1; end
            if (k == 13) start = 1'b0;
            if (k < 46 && div_result !== prev) bad_hold++;
            if (done) begin
                nd++;
                if (fd < 0) begin fd = k; r = div_result; end
            end
        end
        n_checks += 4;
        if (bad_hold !== 0) begin n_fail++; $display("FAIL flush_hold: got %0d changed cycles expected 0", bad_hold); end
        if (fd !== 46) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected 46", fd); end
        if (nd !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", nd); end
        if (r !== 64'h00000001_00000002) begin n_fail++; $display("FAIL restart_result: got %h expected 0000000100000002", r); end
        // flush beats a simultaneous start in IDLE
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1; flush = 1'b1;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0; flush = 1'b0;
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_busy: got %b expected 0", busy); end
            end
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL idle_flush_done: got %0d expected 0", nd); end
    endtask

    task automatic test_back_to_back;
        int d1, d2, nd;
        logic [63:0] r1, r2;
        d1 = -1; d2 = -1; nd = 0; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (d1 < 0) begin d1 = k; r1 = div_result; end
                else if (d2 < 0) begin d2 = k; r2 = div_result; end
            end
            if (k == 34) begin dividend = 32'd9; divisor = 32'd4; end
            if (k == 35) begin
                start = 1'b0;
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
            end
        end
        n_checks += 5;
        if (d1 !== 34) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 34", d1); end
        if (r1 !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 000000020000000e", r1); end
        if (d2 !== 68) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 68", d2); end
        if (r2 !== 64'h00000001_00000002) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0000000100000002", r2); end
        if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
    endtask

    task automatic test_rst_mid;
        int nd;
        nd = 0;
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 15) rst = 1'b1;
            if (k == 16) begin
                rst = 1'b0;
                n_checks += 3;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
                if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
                if (div_result !== 64'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", div_result); end
            end
            if (k >= 16 && done) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL rstmid_late_done: got %0d expected 0", nd); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_boundary();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle iterative 32-bit integer divider. Produces the 64-bit div_result consumed by the ALU for divw, divwu, modw and modwu.
- Radix-2 restoring algorithm on operand magnitudes, followed by a sign fix-up cycle. Signed and unsigned modes are supported.
- Sits beside the ALU in the execute stage. Hazard logic stalls the pipeline while busy is high and releases it on the done pulse.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, div_result is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  operation request; sampled only in IDLE
- is_signed  in  1  1 = signed (divw/modw), 0 = unsigned (divwu/modwu); sampled with start
- flush  in  1  abort any in-flight operation (pipeline flush)
- dividend  in  WIDTH  A operand; sampled with start
- divisor  in  WIDTH  B operand; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; div_result is valid in this cycle
- div_result  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; holds until the next completion

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, div_result=0, counter=0. Reset overrides start and flush and aborts any in-flight operation with no done.
- States: IDLE, CALC, FIX.
- Timing reference: cycle 0 is the cycle in which start=1 is sampled in IDLE.

IDLE:
- start=1 latches the operands and is_signed.
- Magnitudes: in signed mode, negate an operand when its MSB is 1. In unsigned mode, pass operands through.
- Normal case: clear the partial remainder, set the quotient shift register to |dividend|, set counter=0, go to CALC.
- Special case (divisor==0, or signed mode with dividend==0x80000000 and divisor==0xFFFFFFFF): go directly to FIX with a precomputed result.
- start=0: stay in IDLE.

CALC, one quotient bit per cycle:
- Shift {rem, quo} left by 1.
- Form trial = rem_shifted - |divisor| using a WIDTH+1-bit subtract.
- If trial is non-negative: rem = trial and the quotient LSB is 1. Otherwise keep rem_shifted and the quotient LSB is 0.
- counter increments each cycle. After the iteration with counter==WIDTH-1, go to FIX. CALC lasts exactly WIDTH cycles (cycles 1..32).

FIX, one cycle (cycle 33 in the normal case, cycle 1 in the special case):
- Signed mode: negate the quotient if the dividend and divisor signs differ. The remainder takes the dividend's sign; a zero remainder stays 0.
- Register div_result and assert done for exactly 1 cycle. That is cycle 34 in the normal case and cycle 2 in the special case.
- Return to IDLE.

Special results:
- Divide by zero (both modes): quotient = 0xFFFFFFFF, remainder = dividend (original, unsigned view).
- Signed overflow: quotient = 0x80000000, remainder = 0.

busy:
- Registered; equals 1 exactly when state is CALC or FIX.
- busy is 0 in the done cycle, so a new start may be issued in the done cycle itself.

start handling:
- start while busy=1 is ignored; no queueing.

flush:
- flush=1 at an edge in CALC or FIX forces IDLE: busy=0 next cycle and no done pulse. div_result keeps its previous value.
- flush in IDLE takes priority over a simultaneous start; the start is dropped.

Other rules:
- div_result changes only in FIX or on reset.
- done is never asserted twice for one operation.
- Arithmetic is purely two's complement modulo 2^WIDTH. No X propagation from idle operands.

Test Plan:
- Unsigned: 100 / 7 (is_signed=0), start in cycle 0 -> busy cycles 1..33; done in cycle 34 only; div_result = 0x00000002_0000000E.
- Signed: -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Special cases:
  - 5 / 0 (either mode) -> done in cycle 2; div_result = 0x00000005_FFFFFFFF.
  - Signed 0x80000000 / 0xFFFFFFFF -> done in cycle 2; div_result = 0x00000000_80000000.
  - Unsigned 0x80000000 / 0xFFFFFFFF -> full-latency path; quotient 0, remainder 0x80000000.
- Unsigned boundary: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0. 0 / 0x12345678 -> 0x0 result.
- Flush and restart: start 100/7, flush in cycle 10 -> busy=0 from cycle 11, no done, div_result unchanged. Start 9/4 in cycle 12 -> done in cycle 46 with 0x00000001_00000002.
- Control robustness:
  - start held high through the whole operation -> only one done at cycle 34, then the back-to-back start is accepted in the done cycle.
  - rst in cycle 15 -> busy=0, done=0, div_result=0 next cycle; no done afterwards.
